// File: rtl/sha1_block_loader.sv
// SHA-1 block loader: collects up to MAXW big-endian message words, appends
// the SHA-1 padding and length, and emits one 512-bit block with the chaining
// state that came in alongside the message's first word.
module sha1_block_loader #(
  parameter int MAXW = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [159:0] in_ihv,
  output logic [511:0] msg_out,
  output logic [31:0]  d_out,
  output logic [159:0] ihv_out,
  output logic         out_valid,
  output logic         err
);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] EMIT    = 2'd1;
  localparam logic [1:0] DROP    = 2'd2;

  logic [1:0]   r_state;
  logic [3:0]   r_cnt;
  logic [31:0]  r_buf [0:15];
  logic [159:0] r_ihv;
  logic [511:0] r_msg;
  logic [159:0] r_ihv_out;
  logic [31:0]  r_d;
  logic         r_vld;
  logic         r_err;

  logic         w_acc;
  logic [3:0]   w_n;
  logic [511:0] w_blk;
  logic [159:0] w_ihv;

  assign in_ready  = ~rst & (r_state != EMIT);
  assign w_acc     = in_valid & in_ready;
  assign w_n       = r_cnt + 4'd1;
  // A 1-word message never touched r_ihv, so take the IHV straight off the bus.
  assign w_ihv     = (r_cnt == 4'd0) ? in_ihv : r_ihv;

  assign msg_out   = r_msg;
  assign d_out     = r_d;
  assign ihv_out   = r_ihv_out;
  assign out_valid = r_vld;
  assign err       = r_err;

  // Padded block assembled from the buffer plus the word being accepted now.
  // Slots at or above cnt never read the buffer, so stale words cannot leak.
  always_comb begin
    w_blk = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15)
        w_blk[i*32 +: 32] = {23'd0, w_n, 5'd0};
      else if (4'(i) < r_cnt)
        w_blk[i*32 +: 32] = r_buf[i];
      else if (4'(i) == r_cnt)
        w_blk[i*32 +: 32] = in_data;
      else if (4'(i) == w_n)
        w_blk[i*32 +: 32] = 32'h8000_0000;
      else
        w_blk[i*32 +: 32] = 32'd0;
    end
  end

  // Message buffer and IHV latch; no reset needed since the pad logic masks them.
  always_ff @(posedge clk) begin
    if (!rst && w_acc && r_state == COLLECT) begin
      r_buf[r_cnt] <= in_data;
      if (r_cnt == 4'd0) r_ihv <= in_ihv;
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= COLLECT;
      r_cnt     <= 4'd0;
      r_vld     <= 1'b0;
      r_err     <= 1'b0;
      r_msg     <= '0;
      r_ihv_out <= '0;
      r_d       <= '0;
    end else begin
      r_vld <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_acc) begin
            // With MAXW <= 13 a last word always fits (cnt+1 <= MAXW), so
            // the only overflow path is a non-last word in the final slot.
            if (in_last) begin
              r_state   <= EMIT;
              r_cnt     <= 4'd0;
              r_msg     <= w_blk;
              r_ihv_out <= w_ihv;
              r_d       <= w_ihv[31:0];
              r_vld     <= 1'b1;
            end else if (r_cnt == 4'(MAXW - 1)) begin
              r_state <= DROP;
              r_cnt   <= 4'd0;
              r_err   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        EMIT:    r_state <= COLLECT;
        DROP:    if (w_acc && in_last) r_state <= COLLECT;
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_block_loader.sv
// Randomized self-checking bench for sha1_block_loader against a padding model.
module tb_sha1_block_loader;

  localparam int MAXW = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [159:0] in_ihv;
  logic [511:0] msg_out;
  logic [31:0]  d_out;
  logic [159:0] ihv_out;
  logic         out_valid;
  logic         err;

  sha1_block_loader #(.MAXW(MAXW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_ihv(in_ihv),
    .msg_out(msg_out), .d_out(d_out), .ihv_out(ihv_out),
    .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [511:0] m;
    logic [159:0] ihv;
    logic [31:0]  d;
    int           cyc;
  } out_t;

  out_t outq[$];
  int   errq[$];
  int   rdylo[$];

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    out_t o;
    if (out_valid === 1'b1) begin
      o.m = msg_out; o.ihv = ihv_out; o.d = d_out; o.cyc = cyc;
      outq.push_back(o);
    end
    if (err === 1'b1) errq.push_back(cyc);
    if (rst === 1'b0 && in_ready !== 1'b1) rdylo.push_back(cyc);
  end

  int pass_cnt = 0;
  int tot = 0;

  logic [31:0] msg [0:31];
  int          acc [0:31];

  // Reference: SHA-1 padding of an n-word message held in msg[].
  function automatic logic [511:0] pad_ref(input int n);
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[32*i +: 32] = msg[i];
    b[32*n +: 32] = 32'h8000_0000;
    b[480 +: 32]  = 32'(32 * n);
    return b;
  endfunction

  function automatic logic [159:0] rnd160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive msg[0..n-1]; gap_pct is the chance of an idle cycle before a word.
  task automatic send_msg(input int n, input bit do_last,
                          input logic [159:0] ihv, input int gap_pct);
    int w = 0;
    int guard = 0;
    while (w < n) begin
      @(negedge clk);
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom_range(1));
        in_ihv   = rnd160();
      end else begin
        in_valid = 1'b1;
        in_data  = msg[w];
        in_last  = do_last && (w == n - 1);
        in_ihv   = (w == 0) ? ihv : rnd160();
        if (in_ready === 1'b1) begin
          acc[w] = cyc + 1;
          w++;
        end
      end
      guard++;
      if (guard > 2000) begin
        tot++;
        $display("FAIL send_timeout: accepted %0d words, required %0d", w, n);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic clear_q();
    outq.delete(); errq.delete(); rdylo.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_ihv = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tot++; if ({out_valid, err} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {out_valid, err}); else pass_cnt++;
    tot++; if (msg_out !== '0) $display("FAIL rst_msg: got %h want 0", msg_out); else pass_cnt++;
    tot++; if (ihv_out !== '0 || d_out !== '0) $display("FAIL rst_ihv: got %h/%h want 0", ihv_out, d_out); else pass_cnt++;
    tot++; if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", in_ready); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    tot++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_one_word();
    logic [159:0] ihv;
    logic [511:0] exp_m;
    clear_q();
    ihv = {rnd160() >> 32, 32'hC3D2_E1F0};
    msg[0] = 32'h6162_6364;
    send_msg(1, 1'b1, ihv, 0);
    repeat (3) @(negedge clk);
    exp_m = pad_ref(1);
    tot++; if (outq.size() != 1) $display("FAIL one_count: got %0d want 1", outq.size()); else pass_cnt++;
    if (outq.size() >= 1) begin
      tot++; if (outq[0].m !== exp_m) $display("FAIL one_msg: got %h want %h", outq[0].m, exp_m); else pass_cnt++;
      tot++; if (outq[0].m[63:32] !== 32'h8000_0000 || outq[0].m[511:480] !== 32'h20)
        $display("FAIL one_pad: got w1=%h w15=%h want 80000000/00000020", outq[0].m[63:32], outq[0].m[511:480]); else pass_cnt++;
      tot++; if (outq[0].d !== 32'hC3D2_E1F0) $display("FAIL one_d: got %h want c3d2e1f0", outq[0].d); else pass_cnt++;
      tot++; if (outq[0].ihv !== ihv) $display("FAIL one_ihv: got %h want %h", outq[0].ihv, ihv); else pass_cnt++;
      tot++; if (outq[0].cyc != acc[0]) $display("FAIL one_latency: got cyc %0d want %0d", outq[0].cyc, acc[0]); else pass_cnt++;
    end
    tot++; if (errq.size() != 0) $display("FAIL one_err: got %0d want 0", errq.size()); else pass_cnt++;
  endtask

  task automatic test_max_len();
    logic [159:0] ihv;
    logic [511:0] exp_m;
    clear_q();
    ihv = rnd160();
    for (int i = 0; i < 13; i++) msg[i] = 32'(i + 1);
    send_msg(13, 1'b1, ihv, 0);
    repeat (3) @(negedge clk);
    exp_m = pad_ref(13);
    tot++; if (outq.size() != 1) $display("FAIL max_count: got %0d want 1", outq.size()); else pass_cnt++;
    if (outq.size() >= 1) begin
      tot++; if (outq[0].m !== exp_m) $display("FAIL max_msg: got %h want %h", outq[0].m, exp_m); else pass_cnt++;
      tot++; if (outq[0].m[511:416] !== {32'h1A0, 32'h0, 32'h8000_0000})
        $display("FAIL max_pad: got %h want 000001a0_00000000_80000000", outq[0].m[511:416]); else pass_cnt++;
      tot++; if (outq[0].cyc != acc[12]) $display("FAIL max_latency: got cyc %0d want %0d", outq[0].cyc, acc[12]); else pass_cnt++;
      tot++; if (outq[0].ihv !== ihv || outq[0].d !== ihv[31:0]) $display("FAIL max_ihv: got %h want %h", outq[0].ihv, ihv); else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    logic [159:0] ihv;
    logic [511:0] exp_m;
    int err_at;
    clear_q();
    for (int i = 0; i < 14; i++) msg[i] = $urandom;
    send_msg(14, 1'b1, rnd160(), 0);
    err_at = acc[12];
    repeat (3) @(negedge clk);
    tot++; if (errq.size() != 1) $display("FAIL ovf_err_count: got %0d want 1", errq.size()); else pass_cnt++;
    if (errq.size() >= 1) begin
      tot++; if (errq[0] != err_at) $display("FAIL ovf_err_cycle: got %0d want %0d", errq[0], err_at); else pass_cnt++;
    end
    tot++; if (outq.size() != 0) $display("FAIL ovf_no_out: got %0d want 0", outq.size()); else pass_cnt++;
    clear_q();
    ihv = rnd160();
    msg[0] = $urandom; msg[1] = $urandom;
    send_msg(2, 1'b1, ihv, 0);
    repeat (3) @(negedge clk);
    exp_m = pad_ref(2);
    tot++; if (outq.size() != 1) $display("FAIL ovf_next_count: got %0d want 1", outq.size()); else pass_cnt++;
    if (outq.size() >= 1) begin
      tot++; if (outq[0].m !== exp_m || outq[0].m[511:480] !== 32'h40)
        $display("FAIL ovf_next_msg: got %h want %h", outq[0].m, exp_m); else pass_cnt++;
      tot++; if (outq[0].ihv !== ihv) $display("FAIL ovf_next_ihv: got %h want %h", outq[0].ihv, ihv); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [159:0] ihv [0:2];
    logic [511:0] exp_m [0:2];
    int exp_c [0:2];
    clear_q();
    for (int k = 0; k < 3; k++) ihv[k] = rnd160();
    // 16-word overlong message, then a 1-word one with no idle gap.
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    send_msg(16, 1'b1, rnd160(), 0);
    msg[0] = $urandom;
    send_msg(1, 1'b1, ihv[0], 0);
    exp_m[0] = pad_ref(1); exp_c[0] = acc[0];
    // Full-length message straight into a 1-word message.
    for (int i = 0; i < 13; i++) msg[i] = $urandom;
    send_msg(13, 1'b1, ihv[1], 0);
    exp_m[1] = pad_ref(13); exp_c[1] = acc[12];
    msg[0] = $urandom;
    send_msg(1, 1'b1, ihv[2], 0);
    exp_m[2] = pad_ref(1); exp_c[2] = acc[0];
    repeat (3) @(negedge clk);
    tot++; if (outq.size() != 3) $display("FAIL b2b_count: got %0d want 3", outq.size()); else pass_cnt++;
    tot++; if (errq.size() != 1) $display("FAIL b2b_err: got %0d want 1", errq.size()); else pass_cnt++;
    for (int k = 0; k < 3 && k < outq.size(); k++) begin
      tot++; if (outq[k].m !== exp_m[k]) $display("FAIL b2b_msg%0d: got %h want %h", k, outq[k].m, exp_m[k]); else pass_cnt++;
      tot++; if (outq[k].cyc != exp_c[k] || outq[k].ihv !== ihv[k])
        $display("FAIL b2b_timing%0d: got cyc %0d want %0d", k, outq[k].cyc, exp_c[k]); else pass_cnt++;
    end
    tot++; if (rdylo.size() != 3) $display("FAIL b2b_ready_lo: got %0d cycles want 3", rdylo.size()); else pass_cnt++;
    for (int k = 0; k < 3 && k < rdylo.size(); k++) begin
      tot++; if (rdylo[k] != exp_c[k]) $display("FAIL b2b_ready_cyc%0d: got %0d want %0d", k, rdylo[k], exp_c[k]); else pass_cnt++;
    end
    // Outputs hold the last block until the next emit.
    tot++; if (msg_out !== exp_m[2]) $display("FAIL b2b_hold: got %h want %h", msg_out, exp_m[2]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [159:0] ihv;
    logic [511:0] exp_m;
    clear_q();
    for (int i = 0; i < 5; i++) msg[i] = $urandom;
    send_msg(5, 1'b0, rnd160(), 0);
    @(negedge clk);
    // Reset wins over a word offered in the same cycle.
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = $urandom; in_ihv = rnd160();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    tot++; if (outq.size() != 0 || errq.size() != 0)
      $display("FAIL rstmid_quiet: got out=%0d err=%0d want 0/0", outq.size(), errq.size()); else pass_cnt++;
    ihv = rnd160();
    for (int i = 0; i < 3; i++) msg[i] = $urandom;
    send_msg(3, 1'b1, ihv, 0);
    repeat (3) @(negedge clk);
    exp_m = pad_ref(3);
    tot++; if (outq.size() != 1) $display("FAIL rstmid_count: got %0d want 1", outq.size()); else pass_cnt++;
    if (outq.size() >= 1) begin
      tot++; if (outq[0].m !== exp_m || outq[0].m[127:96] !== 32'h8000_0000 || outq[0].m[511:480] !== 32'h60)
        $display("FAIL rstmid_msg: got %h want %h", outq[0].m, exp_m); else pass_cnt++;
      tot++; if (outq[0].ihv !== ihv || outq[0].d !== ihv[31:0])
        $display("FAIL rstmid_ihv: got %h want %h", outq[0].ihv, ihv); else pass_cnt++;
    end
  endtask

  task automatic test_gaps();
    logic [159:0] ihv;
    logic [511:0] exp_m;
    int n;
    for (int t = 0; t < 8; t++) begin
      clear_q();
      n = (t < 4) ? 4 : $urandom_range(1, MAXW);
      ihv = rnd160();
      for (int i = 0; i < n; i++) msg[i] = $urandom;
      send_msg(n, 1'b1, ihv, 50);
      repeat (3) @(negedge clk);
      exp_m = pad_ref(n);
      tot++; if (outq.size() != 1) $display("FAIL gap%0d_count: got %0d want 1", t, outq.size()); else pass_cnt++;
      if (outq.size() >= 1) begin
        tot++; if (outq[0].m !== exp_m) $display("FAIL gap%0d_msg n=%0d: got %h want %h", t, n, outq[0].m, exp_m); else pass_cnt++;
        tot++; if (outq[0].ihv !== ihv || outq[0].cyc != acc[n-1])
          $display("FAIL gap%0d_ihv_cyc: got cyc %0d want %0d", t, outq[0].cyc, acc[n-1]); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_max_len();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_gaps();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end

endmodule
